exec_flag_ctrl: RTL and testbench
=================================

# exec_flag_ctrl

Execute-stage flag controller that owns the processor's condition-code register (CCR) and sequences how ALU results, branch tests and interrupt entry/return modify it. It sits beside the ALU. It decodes the 4-bit ALU opcode into a per-flag write mask and commits the ALU's flag outputs into the CCR. It evaluates conditional branches against the CCR and saves/restores the CCR on a small hardware stack during interrupt entry and RTI.

## Interface
- DEPTH, 2, entries in the CCR save stack (1..8)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  execute-stage instruction valid this cycle
- in_op  in  4  ALU opcode (ADD 0000, SUB 0010, AND 0011, OR 0100, INC 0101, DEC 0110, NOT 0111, NOP 1000, SETC 1001, CLRC 1010, SHL 1011, SHR 1100)
- in_flag_we  in  1  instruction is allowed to write flags
- alu_flags  in  3  flags from ALU: [2]=Z, [1]=N, [0]=C
- stall  in  1  execute stage frozen this cycle
- flush  in  1  execute-stage instruction squashed this cycle
- br_valid  in  1  conditional branch in execute
- br_cond  in  2  00 none, 01 JZ, 10 JN, 11 JC
- int_req  in  1  interrupt entry request (pulse)
- rti  in  1  return-from-interrupt (pulse)
- flags  out  3  registered CCR, also fed to ALU in_flags
- br_taken  out  1  branch condition true (combinational)
- busy  out  1  controller in SAVE/RESTORE; upstream must stall
- int_ack  out  1  high for the SAVE cycle
- stk_err  out  1  sticky overflow/underflow indicator

## Operation
- FSM states: RUN, SAVE, RESTORE. Reset state RUN.
- RUN→SAVE: int_req=1 and stall=0. RUN→RESTORE: rti=1 and stall=0. If both are asserted, rti wins and int_req is ignored (not queued). SAVE→RUN and RESTORE→RUN unconditionally after one cycle.
- Commit condition: state=RUN, in_valid=1, in_flag_we=1, stall=0, flush=0. No commit while busy.
- Write masks (Z,N,C):
  - ADD/SUB/INC/DEC/SHL/SHR: 111, value from alu_flags.
  - AND/OR/NOT: 110; C is kept.
  - SETC: 001 with C forced to 1. CLRC: 001 with C forced to 0.
  - NOP and undefined opcodes: 000.
- Branch:
  - br_taken = br_valid & cond-selected CCR bit; br_cond=00 gives 0.
  - A taken branch in RUN with stall=0 and flush=0 clears the tested bit next cycle.
  - If a commit writes the same bit in the same cycle, the commit wins.
- SAVE:
  - Push the current CCR at stack[ptr] and increment ptr.
  - CCR is cleared to 000 at the end of the SAVE cycle.
  - Push when ptr=DEPTH: overwrite the top entry, leave ptr unchanged, set stk_err.
- RESTORE:
  - Decrement ptr and load the CCR from the popped entry.
  - Pop when ptr=0: CCR unchanged, ptr stays 0, set stk_err.
- stk_err is cleared only by reset.
- Reset mid-SAVE/RESTORE: the operation is abandoned, the stack is emptied and no partial update remains.

## Timing
- Reset values: flags=000, br_taken follows inputs (0 when br_valid=0), busy=0, int_ack=0, stk_err=0, ptr=0, state RUN.
- A flag commit is visible on flags one cycle after the commit edge, so an ALU op in cycle N makes flags valid in cycle N+1.
- busy and int_ack are decoded from registered state. They are high for exactly one cycle, the cycle after int_req/rti is sampled.
- The restored CCR appears on flags in the cycle after RESTORE, i.e. two cycles after rti is sampled.
- br_taken has zero latency from br_valid/br_cond and uses the pre-edge CCR.
- stall holds the CCR, ptr and state (in RUN). int_req/rti sampled during stall are dropped. Requesters hold them until stall drops.

## Test plan
- Reset:
  - Stimulus: assert rst=0 mid-stream with flags=111 and ptr=1, then release.
  - Required: flags=000, busy=0, stk_err=0. A following rti sets stk_err=1 and leaves flags=000.
- Masks:
  - Stimulus: CCR=001; in_op=AND with alu_flags=110.
  - Required: flags=111 next cycle.
  - Stimulus: then SETC, then CLRC.
  - Required: flags=111, then 110.
- Gating:
  - Stimulus: ADD with alu_flags=101 under stall=1, then flush=1, then in_flag_we=0.
  - Required: CCR unchanged in all three cycles. With all three deasserted: flags=101.
- Branch:
  - Stimulus: CCR=100, br_cond=01, br_valid=1.
  - Required: br_taken=1 and flags=000 next cycle.
  - Stimulus: repeat with a simultaneous ADD committing Z=1.
  - Required: flags=100.
- Interrupt nesting (DEPTH=2):
  - Stimulus: CCR=011; int_req → SAVE; commit 100; int_req → SAVE.
  - Required: int_ack and busy high one cycle each time; flags=000 after each SAVE.
  - Stimulus: then rti, rti.
  - Required: flags=100, then 011.
- Overflow and precedence:
  - Stimulus: three pushes at DEPTH=2.
  - Required: stk_err=1, ptr=2.
  - Stimulus: int_req and rti in the same cycle.
  - Required: RESTORE entered; no push occurs.

Source files
------------

// File: rtl/exec_flag_ctrl.sv
// rtl/exec_flag_ctrl.sv - execute-stage condition-code register controller
//
// Owns the CCR (Z,N,C). It commits ALU flags through an opcode-derived write
// mask, evaluates conditional branches, and saves/restores the CCR on a small
// hardware stack for interrupt entry and RTI.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid, in_op     execute-stage instruction valid and 4-bit ALU opcode
//   in_flag_we          instruction may write flags
//   alu_flags           ALU flag results {Z,N,C}
//   stall, flush        execute stage frozen / instruction squashed
//   br_valid, br_cond   conditional branch and its condition (JZ/JN/JC)
//   int_req, rti        interrupt entry / return requests
//   flags               registered CCR {Z,N,C}
//   br_taken            branch condition true (combinational)
//   busy, int_ack       SAVE/RESTORE in progress, SAVE cycle
//   stk_err             sticky stack overflow/underflow
module exec_flag_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_op,
    input  logic       in_flag_we,
    input  logic [2:0] alu_flags,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [1:0] br_cond,
    input  logic       int_req,
    input  logic       rti,
    output logic [2:0] flags,
    output logic       br_taken,
    output logic       busy,
    output logic       int_ack,
    output logic       stk_err
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SAVE,
        ST_RESTORE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    flags_q, flags_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          stk_err_q, stk_err_d;
    logic [2:0]    stack_q [DEPTH];
    logic [2:0]    stack_d [DEPTH];

    logic [2:0]    wr_mask;
    logic [2:0]    wr_val;
    logic [2:0]    br_bit;
    logic          commit;
    logic          br_clear;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;

    // Opcode to per-flag write mask and write value.
    always_comb begin
        wr_mask = 3'b000;
        wr_val  = alu_flags;
        case (in_op)
            4'b0000, 4'b0010, 4'b0101,
            4'b0110, 4'b1011, 4'b1100: wr_mask = 3'b111;
            4'b0011, 4'b0100, 4'b0111: wr_mask = 3'b110;
            4'b1001: begin
                wr_mask = 3'b001;
                wr_val  = 3'b001;
            end
            4'b1010: begin
                wr_mask = 3'b001;
                wr_val  = 3'b000;
            end
            default: wr_mask = 3'b000;
        endcase
    end

    // One-hot select of the CCR bit a branch tests.
    always_comb begin
        case (br_cond)
            2'b01:   br_bit = 3'b100;
            2'b10:   br_bit = 3'b010;
            2'b11:   br_bit = 3'b001;
            default: br_bit = 3'b000;
        endcase
    end

    assign br_taken = br_valid & (|(flags_q & br_bit));
    assign commit   = (state_q == ST_RUN) & in_valid & in_flag_we & ~stall & ~flush;
    assign br_clear = (state_q == ST_RUN) & br_taken & ~stall & ~flush;

    // A push onto a full stack overwrites the top entry.
    assign push_idx = (ptr_q == PTR_FULL) ? IW'(DEPTH - 1) : IW'(ptr_q);
    assign pop_idx  = IW'(ptr_q - PW'(1));

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        ptr_d     = ptr_q;
        stk_err_d = stk_err_q;
        stack_d   = stack_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (rti) begin
                        state_d = ST_RESTORE;
                    end else if (int_req) begin
                        state_d = ST_SAVE;
                    end
                end
                if (br_clear) begin
                    flags_d = flags_d & ~br_bit;
                end
                // Applied after the branch clear so a commit to the same bit wins.
                if (commit) begin
                    flags_d = (flags_d & ~wr_mask) | (wr_val & wr_mask);
                end
            end
            ST_SAVE: begin
                stack_d[push_idx] = flags_q;
                if (ptr_q == PTR_FULL) begin
                    stk_err_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
                flags_d = 3'b000;
                state_d = ST_RUN;
            end
            ST_RESTORE: begin
                if (ptr_q == '0) begin
                    stk_err_d = 1'b1;
                end else begin
                    ptr_d   = ptr_q - PW'(1);
                    flags_d = stack_q[pop_idx];
                end
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            flags_q   <= 3'b000;
            ptr_q     <= '0;
            stk_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= 3'b000;
            end
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            ptr_q     <= ptr_d;
            stk_err_q <= stk_err_d;
            stack_q   <= stack_d;
        end
    end

    assign flags   = flags_q;
    assign busy    = (state_q != ST_RUN);
    assign int_ack = (state_q == ST_SAVE);
    assign stk_err = stk_err_q;

endmodule

// File: tb/tb_exec_flag_ctrl.sv
// tb/tb_exec_flag_ctrl.sv - scoreboard testbench for exec_flag_ctrl
module tb_exec_flag_ctrl;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_SETC = 4'b1001;
    localparam logic [3:0] OP_CLRC = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;

    localparam int F_FLAGS = 0;
    localparam int F_BR    = 1;
    localparam int F_BUSY  = 2;
    localparam int F_ACK   = 3;
    localparam int F_ERR   = 4;
    localparam int F_PTR   = 5;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_op;
    logic       in_flag_we;
    logic [2:0] alu_flags;
    logic       stall;
    logic       flush;
    logic       br_valid;
    logic [1:0] br_cond;
    logic       int_req;
    logic       rti;
    logic [2:0] flags;
    logic       br_taken;
    logic       busy;
    logic       int_ack;
    logic       stk_err;

    exec_flag_ctrl #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_flag_we(in_flag_we),
        .alu_flags (alu_flags),
        .stall     (stall),
        .flush     (flush),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .int_req   (int_req),
        .rti       (rti),
        .flags     (flags),
        .br_taken  (br_taken),
        .busy      (busy),
        .int_ack   (int_ack),
        .stk_err   (stk_err)
    );

    typedef struct {
        int         cyc;
        int         fld;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fname(input int fld);
        case (fld)
            F_FLAGS: return "flags";
            F_BR:    return "br_taken";
            F_BUSY:  return "busy";
            F_ACK:   return "int_ack";
            F_ERR:   return "stk_err";
            default: return "ptr";
        endcase
    endfunction

    function automatic logic [3:0] actual(input int fld);
        case (fld)
            F_FLAGS: return {1'b0, flags};
            F_BR:    return {3'b000, br_taken};
            F_BUSY:  return {3'b000, busy};
            F_ACK:   return {3'b000, int_ack};
            F_ERR:   return {3'b000, stk_err};
            default: return 4'(dut.ptr_q);
        endcase
    endfunction

    // Monitor: on every falling edge, retire the expectations due this cycle.
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (actual(sb[i].fld) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h",
                             fname(sb[i].fld), cyc, actual(sb[i].fld), sb[i].val);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic exp_push(input int d, input int fld, input logic [3:0] v);
        exp_t e;
        e.cyc = cyc + d;
        e.fld = fld;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_op      = OP_NOP;
        in_flag_we = 1'b0;
        alu_flags  = 3'b000;
        stall      = 1'b0;
        flush      = 1'b0;
        br_valid   = 1'b0;
        br_cond    = 2'b00;
        int_req    = 1'b0;
        rti        = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [2:0] f);
        in_valid   = 1'b1;
        in_flag_we = 1'b1;
        in_op      = op;
        alu_flags  = f;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;

        // Reset state
        next();
        exp_push(0, F_FLAGS, 0); exp_push(0, F_BUSY, 0); exp_push(0, F_ACK, 0);
        exp_push(0, F_ERR, 0);   exp_push(0, F_BR, 0);   exp_push(0, F_PTR, 0);
        rst = 1'b1;
        next(); alu(OP_ADD, 3'b111); exp_push(1, F_FLAGS, 7);
        next(); int_req = 1'b1; exp_push(1, F_ACK, 1); exp_push(1, F_BUSY, 1);
        next();
        next(); alu(OP_ADD, 3'b111); int_req = 1'b1;
        exp_push(1, F_FLAGS, 7); exp_push(1, F_PTR, 1); exp_push(1, F_BUSY, 1);
        next();
        // Reset asserted in the middle of a SAVE cycle
        @(negedge clk);
        #1;
        rst = 1'b0;
        next();
        exp_push(0, F_FLAGS, 0); exp_push(0, F_PTR, 0); exp_push(0, F_BUSY, 0);
        exp_push(0, F_ACK, 0);   exp_push(0, F_ERR, 0);
        rst = 1'b1; rti = 1'b1;
        exp_push(1, F_BUSY, 1); exp_push(2, F_ERR, 1); exp_push(2, F_FLAGS, 0); exp_push(2, F_PTR, 0);
        next();
        next();
        next(); rst = 1'b0;
        next(); rst = 1'b1; exp_push(0, F_ERR, 0);

        // Write masks
        next(); alu(OP_ADD, 3'b001);  exp_push(1, F_FLAGS, 1);
        next(); alu(OP_AND, 3'b110);  exp_push(1, F_FLAGS, 7);
        next(); alu(OP_SETC, 3'b000); exp_push(1, F_FLAGS, 7);
        next(); alu(OP_CLRC, 3'b111); exp_push(1, F_FLAGS, 6);
        next(); alu(OP_NOP, 3'b001);  exp_push(1, F_FLAGS, 6);
        next(); alu(4'b1111, 3'b001); exp_push(1, F_FLAGS, 6);
        next(); alu(OP_OR, 3'b001);   exp_push(1, F_FLAGS, 0);
        next(); alu(OP_SHL, 3'b011);  exp_push(1, F_FLAGS, 3);

        // Commit gating
        next(); alu(OP_ADD, 3'b110); exp_push(1, F_FLAGS, 6);
        next(); alu(OP_ADD, 3'b101); stall = 1'b1;      exp_push(1, F_FLAGS, 6);
        next(); alu(OP_ADD, 3'b101); flush = 1'b1;      exp_push(1, F_FLAGS, 6);
        next(); alu(OP_ADD, 3'b101); in_flag_we = 1'b0; exp_push(1, F_FLAGS, 6);
        next(); alu(OP_ADD, 3'b101); in_valid = 1'b0;   exp_push(1, F_FLAGS, 6);
        next(); alu(OP_ADD, 3'b101); exp_push(1, F_FLAGS, 5);

        // Branches
        next(); alu(OP_ADD, 3'b100); exp_push(1, F_FLAGS, 4);
        next(); br_valid = 1'b1; br_cond = 2'b01; exp_push(0, F_BR, 1); exp_push(1, F_FLAGS, 0);
        next(); br_valid = 1'b1; br_cond = 2'b01; exp_push(0, F_BR, 0);
        next(); alu(OP_ADD, 3'b100); exp_push(1, F_FLAGS, 4);
        next(); alu(OP_ADD, 3'b100); br_valid = 1'b1; br_cond = 2'b01;
        exp_push(0, F_BR, 1); exp_push(1, F_FLAGS, 4);
        next(); br_cond = 2'b01; alu(OP_ADD, 3'b111); exp_push(0, F_BR, 0); exp_push(1, F_FLAGS, 7);
        next(); br_valid = 1'b1; br_cond = 2'b00; exp_push(0, F_BR, 0); exp_push(1, F_FLAGS, 7);
        next(); br_valid = 1'b1; br_cond = 2'b10; exp_push(0, F_BR, 1); exp_push(1, F_FLAGS, 5);
        next(); br_valid = 1'b1; br_cond = 2'b11; stall = 1'b1; exp_push(0, F_BR, 1); exp_push(1, F_FLAGS, 5);
        next(); br_valid = 1'b1; br_cond = 2'b11; flush = 1'b1; exp_push(0, F_BR, 1); exp_push(1, F_FLAGS, 5);
        next(); br_valid = 1'b1; br_cond = 2'b11; exp_push(1, F_FLAGS, 4);

        // Interrupt nesting
        next(); alu(OP_ADD, 3'b011); exp_push(1, F_FLAGS, 3);
        next(); int_req = 1'b1;
        exp_push(0, F_BUSY, 0); exp_push(1, F_ACK, 1); exp_push(1, F_BUSY, 1);
        exp_push(2, F_ACK, 0);  exp_push(2, F_BUSY, 0); exp_push(2, F_FLAGS, 0); exp_push(2, F_PTR, 1);
        next(); alu(OP_ADD, 3'b111);
        next(); alu(OP_ADD, 3'b100); exp_push(1, F_FLAGS, 4);
        next(); int_req = 1'b1;
        exp_push(1, F_ACK, 1); exp_push(1, F_BUSY, 1); exp_push(2, F_FLAGS, 0); exp_push(2, F_PTR, 2);
        next();
        next(); rti = 1'b1;
        exp_push(1, F_BUSY, 1); exp_push(1, F_ACK, 0); exp_push(2, F_FLAGS, 4); exp_push(2, F_PTR, 1);
        next();
        next(); rti = 1'b1; exp_push(2, F_FLAGS, 3); exp_push(2, F_PTR, 0); exp_push(2, F_ERR, 0);
        next();
        next();

        // Requests during stall are dropped
        next(); int_req = 1'b1; stall = 1'b1; exp_push(1, F_BUSY, 0); exp_push(1, F_PTR, 0);
        next(); rti = 1'b1; stall = 1'b1;     exp_push(1, F_BUSY, 0); exp_push(1, F_FLAGS, 3);

        // Overflow, then int_req/rti precedence and underflow
        next(); alu(OP_ADD, 3'b001); exp_push(1, F_FLAGS, 1);
        next(); int_req = 1'b1; exp_push(2, F_PTR, 1);
        next();
        next(); alu(OP_ADD, 3'b010);
        next(); int_req = 1'b1; exp_push(2, F_PTR, 2); exp_push(2, F_ERR, 0);
        next();
        next(); alu(OP_ADD, 3'b110);
        next(); int_req = 1'b1;
        exp_push(1, F_ACK, 1); exp_push(2, F_ERR, 1); exp_push(2, F_PTR, 2); exp_push(2, F_FLAGS, 0);
        next();
        next(); int_req = 1'b1; rti = 1'b1;
        exp_push(1, F_BUSY, 1); exp_push(1, F_ACK, 0); exp_push(2, F_PTR, 1); exp_push(2, F_FLAGS, 6);
        next();
        next(); rti = 1'b1; exp_push(2, F_FLAGS, 1); exp_push(2, F_PTR, 0);
        next();
        next(); rti = 1'b1; exp_push(2, F_FLAGS, 1); exp_push(2, F_PTR, 0); exp_push(2, F_ERR, 1);
        next();
        next();
        next();

        // Drain: anything still queued was never checked
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
